// File: rtl/pri_enc_pkg.sv
// Shared types and helpers for the sequential priority-encoder iterator.
// Also provides the HIGH/LOW and ENABLE/DISABLE parameter literals.
`ifndef HIGH
`define HIGH 1
`endif
`ifndef LOW
`define LOW 0
`endif
`ifndef ENABLE
`define ENABLE 1
`endif
`ifndef DISABLE
`define DISABLE 0
`endif

package pri_enc_pkg;

  typedef enum logic {IDLE, SCAN} pri_enc_seq_state_t;

  // Widest vector popcnt can count; callers zero-extend into this width.
  localparam int POPCNT_W = 1024;

  function automatic int unsigned popcnt(input logic [POPCNT_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POPCNT_W; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/pri_enc_seq_lane.sv
// One lane of the iterator: finds the highest-priority set bit of vec,
// reports its index, and passes vec on with that bit cleared.
module pri_enc_seq_lane
  import pri_enc_pkg::*;
#(
  parameter int IN  = 32,
  parameter int MSB = `ENABLE,
  parameter int OUT = $clog2(IN)
) (
  input  logic [IN-1:0]  vec,
  output logic [OUT-1:0] idx,
  output logic           vld,
  output logic [IN-1:0]  vec_nxt
);

  logic [IN-1:0] sel;

  // The last match in loop order wins, so the loop runs towards the priority end.
  always_comb begin
    sel = '0;
    idx = '0;
    if (MSB == `ENABLE) begin
      for (int i = 0; i < IN; i++) begin
        if (vec[i]) begin
          sel    = '0;
          sel[i] = 1'b1;
          idx    = OUT'(i);
        end
      end
    end else begin
      for (int i = IN - 1; i >= 0; i--) begin
        if (vec[i]) begin
          sel    = '0;
          sel[i] = 1'b1;
          idx    = OUT'(i);
        end
      end
    end
  end

  assign vld     = |vec;
  assign vec_nxt = vec & ~sel;

endmodule

// File: rtl/pri_enc_seq.sv
// Sequential priority-encoder iterator: emits every set bit's index, LANES per beat.
// Optional macro PRI_ENC_SEQ_COUNT_EN adds the rem_cnt population-count output.
module pri_enc_seq
  import pri_enc_pkg::*;
#(
  parameter int IN    = 32,
  parameter int ACT   = `HIGH,
  parameter int MSB   = `ENABLE,
  parameter int LANES = 1,
  parameter int OUT   = $clog2(IN)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN-1:0]        in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*OUT-1:0] out_idx,
  output logic [LANES-1:0]     out_lane_vld,
  output logic                 out_last,
  output logic                 busy
`ifdef PRI_ENC_SEQ_COUNT_EN
  ,
  output logic [OUT:0]         rem_cnt
`endif
);

  pri_enc_seq_state_t state, state_nxt;
  logic [IN-1:0] rem, rem_nxt, norm;
  logic [LANES:0][IN-1:0] chain;

  assign norm     = (ACT == `HIGH) ? in : ~in;
  assign chain[0] = rem;

  // rem is zero outside SCAN, so every lane reports idx 0 / invalid while idle.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    pri_enc_seq_lane #(
      .IN (IN),
      .MSB(MSB),
      .OUT(OUT)
    ) u_lane (
      .vec    (chain[k]),
      .idx    (out_idx[k*OUT +: OUT]),
      .vld    (out_lane_vld[k]),
      .vec_nxt(chain[k+1])
    );
  end

  assign busy = (state == SCAN);

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          rem_nxt   = norm;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        out_valid = 1'b1;
        out_last  = ~|chain[LANES];
        if (out_ready) begin
          rem_nxt = chain[LANES];
          if (out_last) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

`ifdef PRI_ENC_SEQ_COUNT_EN
  logic [OUT:0] cnt_nxt;

  always_comb begin
    cnt_nxt = rem_cnt;
    if (state == IDLE && in_valid)
      cnt_nxt = (OUT+1)'(popcnt(POPCNT_W'(norm)));
    else if (state == SCAN && out_ready)
      cnt_nxt = rem_cnt - (OUT+1)'(popcnt(POPCNT_W'(out_lane_vld)));
  end

  always_ff @(posedge clk) begin
    if (reset) rem_cnt <= '0;
    else       rem_cnt <= cnt_nxt;
  end
`endif

endmodule

// File: tb/tb_pri_enc_seq.sv
// Directed, table-driven bench for pri_enc_seq over several parameter sets.
// Build with PRI_ENC_SEQ_COUNT_EN defined to also check rem_cnt.
`ifndef HIGH
`define HIGH 1
`endif
`ifndef LOW
`define LOW 0
`endif
`ifndef ENABLE
`define ENABLE 1
`endif
`ifndef DISABLE
`define DISABLE 0
`endif

module tb_pri_enc_seq;

  localparam int NDUT = 5;
  localparam int P_IN   [NDUT] = '{8, 8, 8, 8, 16};
  localparam int P_LANES[NDUT] = '{1, 1, 2, 1, 4};
  localparam int P_MSB  [NDUT] = '{`DISABLE, `ENABLE, `DISABLE, `ENABLE, `ENABLE};
  localparam int P_ACT  [NDUT] = '{`HIGH, `HIGH, `HIGH, `LOW, `HIGH};

  logic clk = 1'b0;
  logic reset;
  logic        in_valid [NDUT];
  logic        out_ready[NDUT];
  logic [15:0] in_vec   [NDUT];
  logic        in_ready [NDUT];
  logic        out_valid[NDUT];
  logic        out_last [NDUT];
  logic        busy     [NDUT];
  logic [15:0] o_idx    [NDUT];
  logic [3:0]  o_lvld   [NDUT];
  logic [7:0]  o_cnt    [NDUT];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int W = P_IN[g];
    localparam int L = P_LANES[g];
    localparam int O = $clog2(W);
    logic [L*O-1:0] idx_w;
    logic [L-1:0]   vld_w;
    logic [W-1:0]   in_w;
`ifdef PRI_ENC_SEQ_COUNT_EN
    logic [O:0]     cnt_w;
`endif

    assign in_w = in_vec[g][W-1:0];

    pri_enc_seq #(
      .IN   (W),
      .ACT  (P_ACT[g]),
      .MSB  (P_MSB[g]),
      .LANES(L)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid[g]),
      .in_ready    (in_ready[g]),
      .in          (in_w),
      .out_valid   (out_valid[g]),
      .out_ready   (out_ready[g]),
      .out_idx     (idx_w),
      .out_lane_vld(vld_w),
      .out_last    (out_last[g]),
      .busy        (busy[g])
`ifdef PRI_ENC_SEQ_COUNT_EN
      ,
      .rem_cnt     (cnt_w)
`endif
    );

    assign o_idx[g]  = 16'(idx_w);
    assign o_lvld[g] = 4'(vld_w);
`ifdef PRI_ENC_SEQ_COUNT_EN
    assign o_cnt[g] = 8'(cnt_w);
    always @(negedge clk) begin
      nchk++;
      if (32'(cnt_w) != $countones(u_dut.rem)) begin
        nerr++;
        $display("FAIL rem_cnt_inv dut%0d: got %0d required %0d", g, cnt_w, $countones(u_dut.rem));
      end
    end
`else
    assign o_cnt[g] = 8'h00;
`endif
  end

  typedef struct {
    int              d;
    logic [15:0]     v;
    int              nb;
    logic [3:0][15:0] idx;
    logic [3:0][3:0]  vld;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(int d, logic [15:0] v, int nb,
                              logic [15:0] i0, logic [15:0] i1, logic [15:0] i2, logic [15:0] i3,
                              logic [3:0] v0, logic [3:0] v1, logic [3:0] v2, logic [3:0] v3);
    vec_t r;
    r.d = d; r.v = v; r.nb = nb;
    r.idx[0] = i0; r.idx[1] = i1; r.idx[2] = i2; r.idx[3] = i3;
    r.vld[0] = v0; r.vld[1] = v1; r.vld[2] = v2; r.vld[3] = v3;
    return r;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s dut%0d: got %0h required %0h", nm, d, act, req);
    end
  endtask

  task automatic chk_idle(input int d);
    chk("idle_in_ready", d, 32'(in_ready[d]), 1);
    chk("idle_out_valid", d, 32'(out_valid[d]), 0);
    chk("idle_out_last", d, 32'(out_last[d]), 0);
    chk("idle_busy", d, 32'(busy[d]), 0);
    chk("idle_lane_vld", d, 32'(o_lvld[d]), 0);
    chk("idle_idx", d, 32'(o_idx[d]), 0);
`ifdef PRI_ENC_SEQ_COUNT_EN
    chk("idle_cnt", d, 32'(o_cnt[d]), 0);
`endif
  endtask

  // Called at a negedge with DUT d idle; returns at a negedge with it idle again.
  task automatic run_vec(input vec_t t);
    int cnt;
    chk_idle(t.d);
    in_valid[t.d]  = 1'b1;
    in_vec[t.d]    = t.v;
    out_ready[t.d] = 1'b1;
    @(negedge clk);
    in_valid[t.d] = 1'b0;
    for (int b = 0; b < t.nb; b++) begin
      cnt = 0;
      for (int j = b; j < t.nb; j++) cnt += $countones(t.vld[j]);
      chk("beat_valid", t.d, 32'(out_valid[t.d]), 1);
      chk("beat_in_ready", t.d, 32'(in_ready[t.d]), 0);
      chk("beat_busy", t.d, 32'(busy[t.d]), 1);
      chk("beat_idx", t.d, 32'(o_idx[t.d]), 32'(t.idx[b]));
      chk("beat_lane_vld", t.d, 32'(o_lvld[t.d]), 32'(t.vld[b]));
      chk("beat_last", t.d, 32'(out_last[t.d]), (b == t.nb - 1) ? 1 : 0);
`ifdef PRI_ENC_SEQ_COUNT_EN
      chk("beat_cnt", t.d, 32'(o_cnt[t.d]), cnt);
`endif
      @(negedge clk);
    end
    chk_idle(t.d);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      in_vec[i]    = 16'h0000;
    end

    tbl[0]  = mk(0, 16'h00A4, 3, 2, 5, 7, 0, 4'h1, 4'h1, 4'h1, 4'h0);
    tbl[1]  = mk(1, 16'h00A4, 3, 7, 5, 2, 0, 4'h1, 4'h1, 4'h1, 4'h0);
    tbl[2]  = mk(2, 16'h00A4, 2, 16'h002A, 7, 0, 0, 4'h3, 4'h1, 4'h0, 4'h0);
    tbl[3]  = mk(3, 16'h00FE, 1, 0, 0, 0, 0, 4'h1, 4'h0, 4'h0, 4'h0);
    tbl[4]  = mk(3, 16'h00FF, 1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
    tbl[5]  = mk(0, 16'h0000, 1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
    tbl[6]  = mk(2, 16'h00FF, 4, 8, 26, 44, 62, 4'h3, 4'h3, 4'h3, 4'h3);
    tbl[7]  = mk(4, 16'hFFFF, 4, 16'hCDEF, 16'h89AB, 16'h4567, 16'h0123, 4'hF, 4'hF, 4'hF, 4'hF);
    tbl[8]  = mk(4, 16'h8421, 1, 16'h05AF, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0);
    tbl[9]  = mk(4, 16'h0001, 1, 0, 0, 0, 0, 4'h1, 4'h0, 4'h0, 4'h0);
    tbl[10] = mk(1, 16'h0001, 1, 0, 0, 0, 0, 4'h1, 4'h0, 4'h0, 4'h0);
    tbl[11] = mk(4, 16'h0000, 1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
    tbl[12] = mk(2, 16'h0080, 1, 7, 0, 0, 0, 4'h1, 4'h0, 4'h0, 4'h0);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NDUT; i++) chk_idle(i);

    for (int n = 0; n < 13; n++) run_vec(tbl[n]);

    // Backpressure on 8'h81 (MSB first): beat held, in_valid pulses ignored.
    in_valid[1]  = 1'b1;
    in_vec[1]    = 16'h0081;
    out_ready[1] = 1'b0;
    @(negedge clk);
    in_valid[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("bp_valid", 1, 32'(out_valid[1]), 1);
      chk("bp_in_ready", 1, 32'(in_ready[1]), 0);
      chk("bp_idx", 1, 32'(o_idx[1]), 7);
      chk("bp_lane_vld", 1, 32'(o_lvld[1]), 1);
      chk("bp_last", 1, 32'(out_last[1]), 0);
      in_valid[1] = 1'b1;
      in_vec[1]   = 16'h0000;
      @(negedge clk);
    end
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b1;
    chk("bp_idx_held", 1, 32'(o_idx[1]), 7);
    @(negedge clk);
    chk("bp_idx2", 1, 32'(o_idx[1]), 0);
    chk("bp_last2", 1, 32'(out_last[1]), 1);
    @(negedge clk);
    chk_idle(1);
    @(negedge clk);
    chk_idle(1);

    // Reset during the second beat of 8'hFF drops the remaining indices.
    in_valid[0]  = 1'b1;
    in_vec[0]    = 16'h00FF;
    out_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    chk("rst_beat1_idx", 0, 32'(o_idx[0]), 0);
    @(negedge clk);
    chk("rst_beat2_idx", 0, 32'(o_idx[0]), 1);
    chk("rst_beat2_valid", 0, 32'(out_valid[0]), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle(0);
    run_vec(mk(0, 16'h0010, 1, 4, 0, 0, 0, 4'h1, 4'h0, 4'h0, 4'h0));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
